// File: rtl/perf_stat_monitor_if.sv
// Registered counter read port between a host (master) and perf_stat_monitor (slave).
interface perf_stat_monitor_if #(
  parameter int AW    = 6,
  parameter int CNT_W = 32
);
  logic             rd_req;
  logic [AW-1:0]    rd_addr;
  logic             rd_valid;
  logic [CNT_W-1:0] rd_data;
  logic             rd_err;

  modport master (output rd_req, rd_addr, input rd_valid, rd_data, rd_err);
  modport slave  (input rd_req, rd_addr, output rd_valid, rd_data, rd_err);
endinterface

// File: rtl/perf_stat_monitor.sv
// Saturating occupancy counters for pool processors, issuer state and command-source mix,
// frozen at end-of-workload and read back through a one-cycle registered port.
module perf_stat_monitor #(
  parameter int PROC_COUNT   = 4,
  parameter int PROC_STATES  = 9,
  parameter int PROC_STATE_W = 4,
  parameter int ISS_STATES   = 12,
  parameter int ISS_STATE_W  = 4,
  parameter int CNT_W        = 32
) (
  input  logic                             i_clk,
  input  logic                             i_rstn,
  input  logic                             i_enable,
  input  logic                             i_clear,
  input  logic [PROC_COUNT*PROC_STATE_W-1:0] i_proc_states,
  input  logic [ISS_STATE_W-1:0]           i_iss_state,
  input  logic                             i_cmd_get,
  input  logic                             i_cmd_source,
  input  logic                             i_done,
  perf_stat_monitor_if.slave               rd,
  output logic [1:0]                       o_state,
  output logic                             o_overflow,
  output logic                             o_bad_state
);

  localparam int NCNT     = 1 + PROC_COUNT*PROC_STATES + ISS_STATES + 2;
  localparam int AW       = $clog2(NCNT);
  localparam int ISS_BASE = 1 + PROC_COUNT*PROC_STATES;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_COUNT  = 2'd1;
  localparam logic [1:0] ST_FROZEN = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt [NCNT];
  logic [NCNT-1:0]  inc;
  logic             counting;
  logic             hit;
  logic             bad_hit;
  logic             sat_any;

  logic             rd_valid_q;
  logic [CNT_W-1:0] rd_data_q;
  logic             rd_err_q;
  logic             addr_ok;

  // The i_done cycle itself is excluded, and clear always wins.
  assign counting = (state == ST_COUNT) && !i_done && !i_clear;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    inc     = '0;
    hit     = 1'b0;
    bad_hit = 1'b0;
    if (counting) begin
      inc[0] = 1'b1;
      for (int p = 0; p < PROC_COUNT; p++) begin
        hit = 1'b0;
        for (int s = 0; s < PROC_STATES; s++) begin
          if (i_proc_states[p*PROC_STATE_W +: PROC_STATE_W] == PROC_STATE_W'(s)) begin
            inc[1 + p*PROC_STATES + s] = 1'b1;
            hit = 1'b1;
          end
        end
        if (!hit) bad_hit = 1'b1;
      end
      hit = 1'b0;
      for (int k = 0; k < ISS_STATES; k++) begin
        if (i_iss_state == ISS_STATE_W'(k)) begin
          inc[ISS_BASE + k] = 1'b1;
          hit = 1'b1;
        end
      end
      if (!hit) bad_hit = 1'b1;
      if (i_cmd_get) begin
        if (i_cmd_source) inc[NCNT-1] = 1'b1;
        else              inc[NCNT-2] = 1'b1;
      end
    end
  end

  always_comb begin
    sat_any = 1'b0;
    for (int i = 0; i < NCNT; i++) begin
      if (inc[i] && (cnt[i] == '1)) sat_any = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state <= ST_IDLE;
    end else if (i_clear) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (i_enable) state <= ST_COUNT;
        ST_COUNT: if (i_done)   state <= ST_FROZEN;
        default:  state <= state;
      endcase
    end
  end

  // NOTE: the counter array is flop-based and must read 0 right after reset, so it is reset
  // like any other register rather than treated as an uninitialised RAM.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int i = 0; i < NCNT; i++) cnt[i] <= '0;
      o_overflow  <= 1'b0;
      o_bad_state <= 1'b0;
    end else if (i_clear) begin
      for (int i = 0; i < NCNT; i++) cnt[i] <= '0;
      o_overflow  <= 1'b0;
      o_bad_state <= 1'b0;
    end else begin
      for (int i = 0; i < NCNT; i++) begin
        if (inc[i] && (cnt[i] != '1)) cnt[i] <= cnt[i] + 1'b1;
      end
      if (sat_any) o_overflow  <= 1'b1;
      if (bad_hit) o_bad_state <= 1'b1;
    end
  end

  // Widened compare keeps the range check correct even when NCNT is a power of two.
  assign addr_ok = ({1'b0, rd.rd_addr} < (AW+1)'(NCNT));

  // Read port ignores i_clear so a coincident read returns the pre-clear value.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_err_q   <= 1'b0;
    end else if (rd.rd_req) begin
      rd_valid_q <= 1'b1;
      rd_err_q   <= !addr_ok;
      rd_data_q  <= addr_ok ? cnt[rd.rd_addr] : '0;
    end else begin
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
    end
  end

  assign rd.rd_valid = rd_valid_q;
  assign rd.rd_data  = rd_data_q;
  assign rd.rd_err   = rd_err_q;
  assign o_state     = state;

endmodule

// File: tb/tb_perf_stat_monitor.sv
// Directed bench for perf_stat_monitor: a 32-bit instance for function and a 4-bit one for saturation.
module tb_perf_stat_monitor;

  localparam int NCNT = 51;

  logic        clk = 1'b0;
  logic        rstn;
  logic        enable, clear, done;
  logic        s_enable, s_clear, s_done;
  logic [15:0] proc_states;
  logic [3:0]  iss_state;
  logic        cmd_get, cmd_source;
  logic [1:0]  state, s_state;
  logic        overflow, bad_state, s_overflow, s_bad_state;

  int checks   = 0;
  int failures = 0;
  int exp_cnt [NCNT];

  perf_stat_monitor_if #(.AW(6), .CNT_W(32)) rd  ();
  perf_stat_monitor_if #(.AW(6), .CNT_W(4))  rd4 ();

  perf_stat_monitor #(.CNT_W(32)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_enable(enable), .i_clear(clear),
    .i_proc_states(proc_states), .i_iss_state(iss_state), .i_cmd_get(cmd_get),
    .i_cmd_source(cmd_source), .i_done(done), .rd(rd),
    .o_state(state), .o_overflow(overflow), .o_bad_state(bad_state)
  );

  perf_stat_monitor #(.CNT_W(4)) dut_small (
    .i_clk(clk), .i_rstn(rstn), .i_enable(s_enable), .i_clear(s_clear),
    .i_proc_states(proc_states), .i_iss_state(iss_state), .i_cmd_get(cmd_get),
    .i_cmd_source(cmd_source), .i_done(s_done), .rd(rd4),
    .o_state(s_state), .o_overflow(s_overflow), .o_bad_state(s_bad_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_big(input int a, output logic [31:0] d, output logic e, output logic v);
    rd.rd_req  = 1'b1;
    rd.rd_addr = a[5:0];
    tick();
    d = rd.rd_data; e = rd.rd_err; v = rd.rd_valid;
    rd.rd_req = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; enable = 0; clear = 0; done = 0; s_enable = 0; s_clear = 0; s_done = 0;
    proc_states = '0; iss_state = '0; cmd_get = 0; cmd_source = 0;
    rd.rd_req = 0; rd.rd_addr = '0; rd4.rd_req = 0; rd4.rd_addr = '0;
    #12;
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", state); end
    checks++; if (rd.rd_valid !== 1'b0 || rd.rd_err !== 1'b0 || rd.rd_data !== 32'd0) begin
      failures++; $display("FAIL reset_rdport got v=%b e=%b d=%0d exp 0/0/0", rd.rd_valid, rd.rd_err, rd.rd_data); end
    checks++; if (overflow !== 1'b0 || bad_state !== 1'b0) begin
      failures++; $display("FAIL reset_flags got ovf=%b bad=%b exp 0/0", overflow, bad_state); end
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int addrs [7] = '{0, 1, 28, 40, 41, 49, 2};
    int exps  [7] = '{10, 10, 10, 10, 0, 0, 0};
    logic [31:0] d; logic e, v;
    enable = 1; proc_states = '0; iss_state = 4'd3; cmd_get = 0;
    tick();
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL basic_to_count got=%0d exp=1", state); end
    enable = 0;
    repeat (10) tick();
    done = 1; tick(); done = 0;
    checks++; if (state !== 2'd2) begin failures++; $display("FAIL basic_frozen got=%0d exp=2", state); end
    for (int i = 0; i < 7; i++) begin
      read_big(addrs[i], d, e, v);
      checks++;
      if (d !== 32'(exps[i]) || v !== 1'b1 || e !== 1'b0) begin
        failures++; $display("FAIL basic_rd addr=%0d got=%0d v=%b e=%b exp=%0d", addrs[i], d, v, e, exps[i]); end
    end
    clear = 1; tick(); clear = 0;
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL clear_frozen_state got=%0d exp=0", state); end
    read_big(0, d, e, v);
    checks++; if (d !== 32'd0) begin failures++; $display("FAIL clear_frozen_cnt got=%0d exp=0", d); end
  endtask

  task automatic test_mix();
    logic [7:0] src_pat = 8'b1011_1011;
    logic [31:0] d; logic e, v;
    int sum = 0;
    enable = 1; proc_states = '0; iss_state = 4'd5; tick(); enable = 0;
    for (int i = 0; i < 8; i++) begin
      proc_states = {8'd0, (i % 2 == 0) ? 4'd2 : 4'd4, 4'd0};
      cmd_get = 1; cmd_source = src_pat[i];
      tick();
    end
    proc_states = {8'd0, 4'd2, 4'd0}; cmd_source = 1'b1;
    done = 1; tick(); done = 0; cmd_get = 0;
    for (int i = 0; i < NCNT; i++) exp_cnt[i] = 0;
    exp_cnt[0] = 8; exp_cnt[1] = 8; exp_cnt[12] = 4; exp_cnt[14] = 4; exp_cnt[19] = 8;
    exp_cnt[28] = 8; exp_cnt[42] = 8; exp_cnt[49] = 2; exp_cnt[50] = 6;
    read_big(12, d, e, v);
    checks++; if (d !== 32'd4) begin failures++; $display("FAIL mix_p1s2 got=%0d exp=4", d); end
    read_big(14, d, e, v);
    checks++; if (d !== 32'd4) begin failures++; $display("FAIL mix_p1s4 got=%0d exp=4", d); end
    read_big(49, d, e, v);
    checks++; if (d !== 32'd2) begin failures++; $display("FAIL mix_src0 got=%0d exp=2", d); end
    read_big(50, d, e, v);
    checks++; if (d !== 32'd6) begin failures++; $display("FAIL mix_src1 got=%0d exp=6", d); end
    for (int a = 10; a <= 18; a++) begin
      read_big(a, d, e, v);
      sum += int'(d);
    end
    checks++; if (sum !== 8) begin failures++; $display("FAIL mix_p1_sum got=%0d exp=8", sum); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic e, v;
    for (int a = 0; a < NCNT; a++) begin
      rd.rd_req = 1'b1; rd.rd_addr = 6'(a);
      tick();
      checks++;
      if (rd.rd_valid !== 1'b1 || rd.rd_err !== 1'b0 || rd.rd_data !== 32'(exp_cnt[a])) begin
        failures++; $display("FAIL b2b addr=%0d got=%0d v=%b e=%b exp=%0d", a, rd.rd_data, rd.rd_valid, rd.rd_err, exp_cnt[a]); end
    end
    rd.rd_req = 1'b0;
    tick();
    checks++; if (rd.rd_valid !== 1'b0 || rd.rd_data !== 32'd6) begin
      failures++; $display("FAIL b2b_idle_hold got v=%b d=%0d exp v=0 d=6", rd.rd_valid, rd.rd_data); end
    read_big(NCNT, d, e, v);
    checks++; if (e !== 1'b1 || d !== 32'd0 || v !== 1'b1) begin
      failures++; $display("FAIL bad_addr51 got e=%b d=%0d v=%b exp e=1 d=0 v=1", e, d, v); end
    read_big(63, d, e, v);
    checks++; if (e !== 1'b1 || d !== 32'd0) begin failures++; $display("FAIL bad_addr63 got e=%b d=%0d exp e=1 d=0", e, d); end
  endtask

  task automatic test_bad_state();
    logic [31:0] d; logic e, v;
    int sum = 0;
    clear = 1; tick(); clear = 0;
    enable = 1; iss_state = 4'd0; cmd_get = 0; tick(); enable = 0;
    for (int i = 0; i < 6; i++) begin
      proc_states = {12'd0, (i >= 1 && i <= 3) ? 4'd12 : 4'd1};
      if (i == 2) begin rd.rd_req = 1'b1; rd.rd_addr = 6'd0; end
      tick();
      rd.rd_req = 1'b0;
      if (i == 0) begin
        checks++; if (bad_state !== 1'b0) begin failures++; $display("FAIL bad_early got=%b exp=0", bad_state); end
      end
      if (i == 2) begin
        checks++; if (rd.rd_data !== 32'd2) begin failures++; $display("FAIL read_pre_update got=%0d exp=2", rd.rd_data); end
      end
    end
    done = 1; tick(); done = 0;
    checks++; if (bad_state !== 1'b1) begin failures++; $display("FAIL bad_flag got=%b exp=1", bad_state); end
    read_big(0, d, e, v);
    checks++; if (d !== 32'd6) begin failures++; $display("FAIL bad_cycles got=%0d exp=6", d); end
    for (int a = 1; a <= 9; a++) begin
      read_big(a, d, e, v);
      sum += int'(d);
    end
    checks++; if (sum !== 3) begin failures++; $display("FAIL bad_p0_sum got=%0d exp=3", sum); end
  endtask

  task automatic test_clear_done();
    logic [31:0] d; logic e, v;
    clear = 1; tick(); clear = 0;
    proc_states = '0; iss_state = 4'd0;
    enable = 1; tick(); enable = 0;
    for (int i = 0; i < 3; i++) begin
      iss_state = (i == 1) ? 4'd13 : 4'd0;
      tick();
    end
    iss_state = 4'd0;
    checks++; if (bad_state !== 1'b1) begin failures++; $display("FAIL cd_bad_pre got=%b exp=1", bad_state); end
    clear = 1; done = 1; rd.rd_req = 1'b1; rd.rd_addr = 6'd0;
    tick();
    clear = 0; done = 0; rd.rd_req = 1'b0;
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL cd_state got=%0d exp=0", state); end
    checks++; if (rd.rd_data !== 32'd3 || rd.rd_valid !== 1'b1) begin
      failures++; $display("FAIL cd_preclear_read got=%0d v=%b exp=3", rd.rd_data, rd.rd_valid); end
    checks++; if (bad_state !== 1'b0) begin failures++; $display("FAIL cd_bad_cleared got=%b exp=0", bad_state); end
    read_big(37, d, e, v);
    checks++; if (d !== 32'd0) begin failures++; $display("FAIL cd_iss0_cleared got=%0d exp=0", d); end
    read_big(0, d, e, v);
    checks++; if (d !== 32'd0) begin failures++; $display("FAIL cd_cycles_cleared got=%0d exp=0", d); end
  endtask

  task automatic test_saturation();
    int addrs [6] = '{0, 1, 40, 49, 50, 10};
    int exps  [6] = '{15, 15, 15, 15, 0, 15};
    proc_states = '0; iss_state = 4'd3; cmd_get = 1; cmd_source = 0;
    s_enable = 1; tick(); s_enable = 0;
    repeat (15) tick();
    checks++; if (s_overflow !== 1'b0) begin failures++; $display("FAIL sat_early got=%b exp=0", s_overflow); end
    repeat (5) tick();
    s_done = 1; tick(); s_done = 0; cmd_get = 0;
    checks++; if (s_state !== 2'd2 || s_overflow !== 1'b1) begin
      failures++; $display("FAIL sat_flag got st=%0d ovf=%b exp st=2 ovf=1", s_state, s_overflow); end
    for (int i = 0; i < 6; i++) begin
      rd4.rd_req = 1'b1; rd4.rd_addr = 6'(addrs[i]);
      tick();
      rd4.rd_req = 1'b0;
      checks++;
      if (rd4.rd_data !== 4'(exps[i])) begin
        failures++; $display("FAIL sat_rd addr=%0d got=%0d exp=%0d", addrs[i], rd4.rd_data, exps[i]); end
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] d; logic e, v;
    proc_states = '0; iss_state = 4'd1;
    enable = 1; tick(); enable = 0;
    repeat (3) tick();
    rd.rd_req = 1'b1; rd.rd_addr = 6'd0; tick(); rd.rd_req = 1'b0;
    checks++; if (rd.rd_data !== 32'd3) begin failures++; $display("FAIL ar_pre_read got=%0d exp=3", rd.rd_data); end
    #2 rstn = 1'b0;
    #1;
    checks++; if (state !== 2'd0 || rd.rd_data !== 32'd0 || rd.rd_valid !== 1'b0 || s_overflow !== 1'b0) begin
      failures++; $display("FAIL ar_immediate got st=%0d d=%0d v=%b sovf=%b exp 0/0/0/0", state, rd.rd_data, rd.rd_valid, s_overflow); end
    #1 rstn = 1'b1;
    tick();
    read_big(38, d, e, v);
    checks++; if (d !== 32'd0 || state !== 2'd0) begin
      failures++; $display("FAIL ar_cleared got d=%0d st=%0d exp 0/0", d, state); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mix();
    test_back_to_back();
    test_bad_state();
    test_clear_done();
    test_saturation();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
